dom_gf4_mul_sched: RTL and testbench

Scheduler and randomness manager for one shared DOM GF(4) multiplier instance (`real_dom_shared_mul_gf4`, FIRST_ORDER_OPTIMIZATION=1, SHARES=2).
- Arbitrates masked operand requests from REQS requesters, round-robin.
- Pairs every accepted request with one fresh random word from an external PRNG stream. That word supplies Z and B.
- Drives the multiplier inputs and returns the masked product tagged with the requester index.
- Sits between the S-box / inversion control logic and the multiplier datapath.

---
 rtl/dom_gf4_mul_sched.sv | 218 +++++++++++++++++++++
 tb/tb_dom_gf4_mul_sched.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dom_gf4_mul_sched.sv
// dom_gf4_mul_sched: round-robin scheduler and randomness manager for one
// shared 2-share DOM GF(4) multiplier (real_dom_shared_mul_gf4).
// Each accepted request is paired with one fresh random word from a 2-entry
// FIFO (Z in the low bits, B above). The operands are issued to the
// multiplier, and the product returns two cycles later tagged with the
// requester index.
// Optional feature macro: DOM_SCHED_RND_CHECK_EN. When it is defined, a pushed
// word that repeats the previous pushed word, or that is all-zero, sets the
// sticky RndErrxSO flag.
module dom_gf4_mul_sched #(
  parameter int SHARES    = 2,
  parameter int REQS      = 4,
  parameter int PIPELINED = 1,
  localparam int RW = 2 * SHARES * (SHARES - 1) + 4 * SHARES,
  localparam int IW = (REQS > 1) ? $clog2(REQS) : 1,
  localparam int DW = 4 * SHARES,
  localparam int ZW = 2 * SHARES * (SHARES - 1)
) (
  input  logic               ClkxCI,
  input  logic               RstxBI,
  input  logic [REQS-1:0]    ReqValidxSI,
  output logic [REQS-1:0]    ReqReadyxSO,
  input  logic [REQS*DW-1:0] ReqXxDI,
  input  logic [REQS*DW-1:0] ReqYxDI,
  input  logic               RndValidxSI,
  output logic               RndReadyxSO,
  input  logic [RW-1:0]      RndxDI,
  output logic [DW-1:0]      MulXxDO,
  output logic [DW-1:0]      MulYxDO,
  output logic [ZW-1:0]      MulZxDO,
  output logic [DW-1:0]      MulBxDO,
  input  logic [DW-1:0]      MulQxDI,
  output logic               RspValidxSO,
  output logic [IW-1:0]      RspIdxDO,
  output logic [DW-1:0]      RspQxDO,
  output logic               RndErrxSO
);

  localparam int unsigned REQSU = REQS;

  // random word FIFO
  logic [RW-1:0] fifoMem [2];
  logic          fifoWrPtr;
  logic          fifoRdPtr;
  logic [1:0]    fifoCnt;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          fifoPush;
  logic          fifoPop;
  logic [RW-1:0] fifoHead;

  // arbitration
  logic [IW-1:0] ptrQ;
  logic [IW-1:0] cand;
  logic [IW-1:0] candIdx;
  logic          candFound;
  logic          slotFree;
  logic          accept;
  logic          issuedQ;
  logic [DW-1:0] opX;
  logic [DW-1:0] opY;

  // tag pipeline
  logic          tagV1;
  logic          tagV2;
  logic [IW-1:0] tagId1;
  logic [IW-1:0] tagId2;

  assign fifoFull    = (fifoCnt == 2'd2);
  assign fifoEmpty   = (fifoCnt == 2'd0);
  assign RndReadyxSO = ~fifoFull;
  assign fifoPush    = RndValidxSI & ~fifoFull;
  assign fifoPop     = accept;
  assign fifoHead    = fifoMem[fifoRdPtr];

  // FIFO storage, pointers and occupancy; a pop never sees the word pushed in the same cycle
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      fifoWrPtr  <= 1'b0;
      fifoRdPtr  <= 1'b0;
      fifoCnt    <= '0;
    end else begin
      if (fifoPush) begin
        fifoMem[fifoWrPtr] <= RndxDI;
        fifoWrPtr          <= ~fifoWrPtr;
      end
      if (fifoPop) begin
        fifoRdPtr <= ~fifoRdPtr;
      end
      case ({fifoPush, fifoPop})
        2'b10:   fifoCnt <= fifoCnt + 2'd1;
        2'b01:   fifoCnt <= fifoCnt - 2'd1;
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  // the unpipelined multiplier needs a free cycle after every issue
  assign slotFree = (PIPELINED != 0) ? 1'b1 : ~issuedQ;
  assign accept   = candFound & ~fifoEmpty & slotFree;

  // first valid requester at or after the priority pointer, modulo REQS
  always_comb begin
    cand      = '0;
    candIdx   = '0;
    candFound = 1'b0;
    for (int unsigned k = 0; k < REQSU; k++) begin
      cand = IW'((32'(ptrQ) + k) % REQSU);
      if (!candFound && ReqValidxSI[cand]) begin
        candFound = 1'b1;
        candIdx   = cand;
      end
    end
  end

  // one-hot grant, only when the request can actually be issued
  always_comb begin
    ReqReadyxSO = '0;
    if (accept) begin
      ReqReadyxSO[candIdx] = 1'b1;
    end
  end

  // operand select for the winning requester
  always_comb begin
    opX = '0;
    opY = '0;
    for (int unsigned k = 0; k < REQSU; k++) begin
      if (candIdx == IW'(k)) begin
        opX = ReqXxDI[k*DW +: DW];
        opY = ReqYxDI[k*DW +: DW];
      end
    end
  end

  // priority pointer moves just past the last granted requester
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      ptrQ <= '0;
    end else if (accept) begin
      ptrQ <= (candIdx == IW'(REQS - 1)) ? '0 : candIdx + IW'(1);
    end
  end

  // issue registers: randomness appears only in issue cycles; X/Y are held one
  // extra cycle in unpipelined mode, since the multiplier reads X again in its second cycle
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      MulXxDO <= '0;
      MulYxDO <= '0;
      MulZxDO <= '0;
      MulBxDO <= '0;
      issuedQ <= 1'b0;
    end else begin
      issuedQ <= accept;
      if (accept) begin
        MulXxDO <= opX;
        MulYxDO <= opY;
        MulZxDO <= fifoHead[ZW-1:0];
        MulBxDO <= fifoHead[RW-1:ZW];
      end else begin
        MulZxDO <= '0;
        MulBxDO <= '0;
        if (!((PIPELINED == 0) && issuedQ)) begin
          MulXxDO <= '0;
          MulYxDO <= '0;
        end
      end
    end
  end

  // two-stage (valid, id) tag pipeline matching the multiplier latency
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      tagV1  <= 1'b0;
      tagV2  <= 1'b0;
      tagId1 <= '0;
      tagId2 <= '0;
    end else begin
      tagV1  <= accept;
      tagId1 <= accept ? candIdx : '0;
      tagV2  <= tagV1;
      tagId2 <= tagId1;
    end
  end

  assign RspValidxSO = tagV2;
  assign RspIdxDO    = tagId2;
  assign RspQxDO     = tagV2 ? MulQxDI : '0;

`ifdef DOM_SCHED_RND_CHECK_EN
  logic [RW-1:0] prevRndQ;
  logic          havePrevQ;
  logic          rndErrQ;

  // sticky fault on a repeated or all-zero pushed word; scheduling is not affected
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      prevRndQ  <= '0;
      havePrevQ <= 1'b0;
      rndErrQ   <= 1'b0;
    end else if (fifoPush) begin
      prevRndQ  <= RndxDI;
      havePrevQ <= 1'b1;
      if ((havePrevQ && (RndxDI == prevRndQ)) || (RndxDI == '0)) begin
        rndErrQ <= 1'b1;
      end
    end
  end

  assign RndErrxSO = rndErrQ;
`else
  assign RndErrxSO = 1'b0;
`endif

endmodule

// File: tb/tb_dom_gf4_mul_sched.sv
// tb_dom_gf4_mul_sched: checks dom_gf4_mul_sched against a cycle-level
// reference model (queue-based FIFO, pointer arithmetic, due-cycle queues).
// It instantiates one pipelined and one unpipelined scheduler. Each has a
// behavioural 2-cycle masked GF(2^4) multiplier model on its Mul* ports.
`timescale 1ns/1ps
module tb_dom_gf4_mul_sched;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int ZW = 4;
  localparam int RW = 12;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // pipelined instance
  logic [NR-1:0]    reqValid, reqReady;
  logic [NR*DW-1:0] reqX, reqY;
  logic             rndValid, rndReady;
  logic [RW-1:0]    rnd;
  logic [DW-1:0]    mulX, mulY, mulB, mulQ;
  logic [ZW-1:0]    mulZ;
  logic             rspValid;
  logic [IW-1:0]    rspId;
  logic [DW-1:0]    rspQ;
  logic             rndErr;

  // unpipelined instance
  logic [NR-1:0]    r0Valid, r0Ready;
  logic [NR*DW-1:0] r0X, r0Y;
  logic             rnd0Valid, rnd0Ready;
  logic [RW-1:0]    rnd0;
  logic [DW-1:0]    mul0X, mul0Y, mul0B, mul0Q;
  logic [ZW-1:0]    mul0Z;
  logic             rsp0Valid;
  logic [IW-1:0]    rsp0Id;
  logic [DW-1:0]    rsp0Q;
  logic             rnd0Err;

  dom_gf4_mul_sched #(.SHARES(2), .REQS(NR), .PIPELINED(1)) dut (
    .ClkxCI(clk), .RstxBI(rstn),
    .ReqValidxSI(reqValid), .ReqReadyxSO(reqReady),
    .ReqXxDI(reqX), .ReqYxDI(reqY),
    .RndValidxSI(rndValid), .RndReadyxSO(rndReady), .RndxDI(rnd),
    .MulXxDO(mulX), .MulYxDO(mulY), .MulZxDO(mulZ), .MulBxDO(mulB),
    .MulQxDI(mulQ),
    .RspValidxSO(rspValid), .RspIdxDO(rspId), .RspQxDO(rspQ),
    .RndErrxSO(rndErr)
  );

  dom_gf4_mul_sched #(.SHARES(2), .REQS(NR), .PIPELINED(0)) dut0 (
    .ClkxCI(clk), .RstxBI(rstn),
    .ReqValidxSI(r0Valid), .ReqReadyxSO(r0Ready),
    .ReqXxDI(r0X), .ReqYxDI(r0Y),
    .RndValidxSI(rnd0Valid), .RndReadyxSO(rnd0Ready), .RndxDI(rnd0),
    .MulXxDO(mul0X), .MulYxDO(mul0Y), .MulZxDO(mul0Z), .MulBxDO(mul0B),
    .MulQxDI(mul0Q),
    .RspValidxSO(rsp0Valid), .RspIdxDO(rsp0Id), .RspQxDO(rsp0Q),
    .RndErrxSO(rnd0Err)
  );

  // GF(2^4) multiply, polynomial x^4 + x + 1
  function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'b0011) : {aa[2:0], 1'b0};
    end
    return r;
  endfunction

  // multiplier stand-ins: the product of the unmasked operands, remasked with Z, one cycle after issue
  always @(posedge clk) begin
    mulQ  <= {mulZ, gfMul(mulX[3:0] ^ mulX[7:4], mulY[3:0] ^ mulY[7:4]) ^ mulZ};
    mul0Q <= {mul0Z, gfMul(mul0X[3:0] ^ mul0X[7:4], mul0Y[3:0] ^ mul0Y[7:4]) ^ mul0Z};
  end

  // reference model state for the pipelined instance
  typedef struct {
    int unsigned due;
    logic [27:0] mul;
  } issue_t;
  typedef struct {
    int unsigned   due;
    logic [IW-1:0] id;
    logic [DW-1:0] q;
  } rsp_t;

  logic [RW-1:0] mFifo[$];
  issue_t        mIss[$];
  rsp_t          mRsp[$];
  int            mPtr;
  int unsigned   cyc;
  logic          mErr;
  logic [RW-1:0] mPrev;
  bit            mHavePrev;
  logic [NR-1:0] lastReady;

  int nCmp = 0;
  int nErr = 0;

  task automatic modelClear();
    mFifo.delete();
    mIss.delete();
    mRsp.delete();
    mPtr      = 0;
    cyc       = 0;
    mErr      = 1'b0;
    mPrev     = '0;
    mHavePrev = 0;
  endtask

  task automatic idleInputs();
    reqValid  = '0; reqX = '0; reqY = '0; rndValid = 1'b0; rnd = '0;
    r0Valid   = '0; r0X  = '0; r0Y  = '0; rnd0Valid = 1'b0; rnd0 = '0;
  endtask

  // asynchronous reset assertion from the current point, checks outputs in reset, releases on a negedge
  task automatic doReset();
    rstn = 1'b0;
    #2;
    nCmp++;
    if ({reqReady, mulX, mulY, mulZ, mulB, rspValid, rspId, rspQ, rndErr} !== '0) begin
      nErr++;
      $display("FAIL reset_outputs: got %h required 0",
               {reqReady, mulX, mulY, mulZ, mulB, rspValid, rspId, rspQ, rndErr});
    end
    nCmp++;
    if (rndReady !== 1'b1) begin
      nErr++;
      $display("FAIL reset_rndready: got %b required 1", rndReady);
    end
    nCmp++;
    if ({r0Ready, mul0X, mul0Y, mul0Z, mul0B, rsp0Valid, rsp0Id, rsp0Q, rnd0Err, ~rnd0Ready} !== '0) begin
      nErr++;
      $display("FAIL reset_outputs_unpipelined: got %h required 0",
               {r0Ready, mul0X, mul0Y, mul0Z, mul0B, rsp0Valid, rsp0Id, rsp0Q, rnd0Err, ~rnd0Ready});
    end
    @(posedge clk);
    @(posedge clk);
    idleInputs();
    @(negedge clk);
    rstn = 1'b1;
    modelClear();
    @(posedge clk);
    #1;
  endtask

  // one clock cycle of the pipelined instance: check at negedge, advance model, wait for posedge
  task automatic step();
    int            g;
    int unsigned   sz;
    logic [NR-1:0] expReady;
    logic [27:0]   expMul;
    logic          expV;
    logic [IW-1:0] expId;
    logic [DW-1:0] expQ;
    logic [RW-1:0] w;
    logic [DW-1:0] xs, ys;
    issue_t        ni, ei;
    rsp_t          nr, er;

    @(negedge clk);
    sz = mFifo.size();
    g  = -1;
    if (sz > 0) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (mPtr + k) % NR;
        if (g < 0 && reqValid[idx]) g = idx;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    lastReady = reqReady;

    nCmp++;
    if (reqReady !== expReady) begin
      nErr++;
      $display("FAIL grant c%0d: got %b required %b", cyc, reqReady, expReady);
    end
    nCmp++;
    if (rndReady !== (sz < 2)) begin
      nErr++;
      $display("FAIL rnd_ready c%0d: got %b required %b", cyc, rndReady, (sz < 2));
    end

    expMul = '0;
    if (mIss.size() > 0 && mIss[0].due == cyc) begin
      ei     = mIss.pop_front();
      expMul = ei.mul;
    end
    nCmp++;
    if ({mulX, mulY, mulZ, mulB} !== expMul) begin
      nErr++;
      $display("FAIL mul_xyzb c%0d: got %h required %h", cyc, {mulX, mulY, mulZ, mulB}, expMul);
    end

    expV = 1'b0; expId = '0; expQ = '0;
    if (mRsp.size() > 0 && mRsp[0].due == cyc) begin
      er    = mRsp.pop_front();
      expV  = 1'b1;
      expId = er.id;
      expQ  = er.q;
    end
    nCmp++;
    if (rspValid !== expV) begin
      nErr++;
      $display("FAIL rsp_valid c%0d: got %b required %b", cyc, rspValid, expV);
    end
    nCmp++;
    if (rspId !== expId) begin
      nErr++;
      $display("FAIL rsp_id c%0d: got %0d required %0d", cyc, rspId, expId);
    end
    nCmp++;
    if (rspQ !== expQ) begin
      nErr++;
      $display("FAIL rsp_q c%0d: got %h required %h", cyc, rspQ, expQ);
    end
    nCmp++;
    if (rndErr !== mErr) begin
      nErr++;
      $display("FAIL rnd_err c%0d: got %b required %b", cyc, rndErr, mErr);
    end

    if (g >= 0) begin
      w      = mFifo.pop_front();
      xs     = reqX[g*DW +: DW];
      ys     = reqY[g*DW +: DW];
      ni.due = cyc + 1;
      ni.mul = {xs, ys, w[ZW-1:0], w[RW-1:ZW]};
      mIss.push_back(ni);
      nr.due = cyc + 2;
      nr.id  = IW'(g);
      nr.q   = {w[3:0], gfMul(xs[3:0] ^ xs[7:4], ys[3:0] ^ ys[7:4]) ^ w[3:0]};
      mRsp.push_back(nr);
      mPtr   = (g + 1) % NR;
    end
    if (rndValid && sz < 2) begin
`ifdef DOM_SCHED_RND_CHECK_EN
      if ((mHavePrev && rnd == mPrev) || rnd == '0) mErr = 1'b1;
      mPrev     = rnd;
      mHavePrev = 1;
`endif
      mFifo.push_back(rnd);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idleInputs();
    doReset();
    step();
    step();
  endtask

  task automatic test_single();
    doReset();
    rndValid = 1'b1; rnd = 12'hA5C;
    step();
    rndValid = 1'b0;
    reqValid = 4'b0100;
    reqX = {$urandom}; reqY = {$urandom};
    reqX[2*DW +: DW] = 8'h31;
    reqY[2*DW +: DW] = 8'h27;
    step();
    nCmp++;
    if (lastReady !== 4'b0100) begin
      nErr++;
      $display("FAIL single_grant: got %b required 0100", lastReady);
    end
    nCmp++;
    if ({mulZ, mulB} !== 12'hCA5) begin
      nErr++;
      $display("FAIL single_zb: got %h required ca5", {mulZ, mulB});
    end
    reqValid = '0;
    step();
    nCmp++;
    if ({rspValid, rspId, rspQ[3:0] ^ rspQ[7:4]} !== {1'b1, 2'd2, 4'hA}) begin
      nErr++;
      $display("FAIL single_rsp: got v=%b id=%0d p=%h required v=1 id=2 p=a",
               rspValid, rspId, rspQ[3:0] ^ rspQ[7:4]);
    end
    step();
    step();
  endtask

  task automatic test_round_robin();
    doReset();
    rndValid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rnd = 12'($urandom_range(1, 4095));
      step();
    end
    for (int k = 0; k < 8; k++) begin
      reqValid = 4'b1111;
      reqX = $urandom; reqY = $urandom;
      rnd = 12'($urandom_range(1, 4095));
      step();
      nCmp++;
      if (lastReady !== (4'b0001 << (k % 4))) begin
        nErr++;
        $display("FAIL rr_order k%0d: got %b required %b", k, lastReady, 4'b0001 << (k % 4));
      end
    end
    idleInputs();
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_starvation();
    doReset();
    for (int k = 0; k < 5; k++) begin
      reqValid = 4'($urandom_range(1, 15));
      reqX = $urandom; reqY = $urandom;
      step();
      nCmp++;
      if ({lastReady, rspValid, mulZ, mulB} !== '0) begin
        nErr++;
        $display("FAIL starve k%0d: got %h required 0", k, {lastReady, rspValid, mulZ, mulB});
      end
    end
    rndValid = 1'b1; rnd = 12'h3C9; reqValid = 4'b1111;
    step();
    nCmp++;
    if (lastReady !== 4'b0000) begin
      nErr++;
      $display("FAIL starve_push_cycle: got %b required 0000", lastReady);
    end
    rndValid = 1'b0;
    step();
    nCmp++;
    if (lastReady !== 4'b0001) begin
      nErr++;
      $display("FAIL starve_first_grant: got %b required 0001", lastReady);
    end
    idleInputs();
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int k = 0; k < 8; k++) begin
      reqValid = 4'b0010; rndValid = 1'b1;
      rnd = 12'($urandom_range(1, 4095));
      reqX = $urandom; reqY = $urandom;
      step();
      nCmp++;
      if (lastReady !== ((k == 0) ? 4'b0000 : 4'b0010)) begin
        nErr++;
        $display("FAIL b2b k%0d: got %b required %b", k, lastReady, (k == 0) ? 4'b0000 : 4'b0010);
      end
    end
    idleInputs();
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_random();
    logic [RW-1:0] prevW;
    doReset();
    prevW = '0;
    for (int k = 0; k < 400; k++) begin
      reqValid = 4'($urandom);
      reqX = $urandom; reqY = $urandom;
      rndValid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0:       rnd = prevW;
        1:       rnd = '0;
        default: rnd = 12'($urandom);
      endcase
      prevW = rnd;
      step();
    end
    idleInputs();
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_unpipelined();
    logic [DW-1:0] xg[16];
    logic [DW-1:0] yg[16];
    bit            gr[16];
    logic [DW-1:0] expX;
    logic [3:0]    expP;
    doReset();
    for (int k = 0; k < 16; k++) begin
      r0Valid = 4'b0001; rnd0Valid = 1'b1;
      rnd0 = 12'($urandom_range(1, 4095));
      r0X = $urandom; r0Y = $urandom;
      gr[k] = (k >= 1) && ((k - 1) % 2 == 0);
      xg[k] = r0X[DW-1:0];
      yg[k] = r0Y[DW-1:0];
      @(negedge clk);
      nCmp++;
      if (r0Ready !== (gr[k] ? 4'b0001 : 4'b0000)) begin
        nErr++;
        $display("FAIL np_grant k%0d: got %b required %b", k, r0Ready, gr[k] ? 4'b0001 : 4'b0000);
      end
      expX = '0;
      if (k >= 1 && gr[k-1]) expX = xg[k-1];
      else if (k >= 2 && gr[k-2]) expX = xg[k-2];
      nCmp++;
      if (mul0X !== expX) begin
        nErr++;
        $display("FAIL np_mulx k%0d: got %h required %h", k, mul0X, expX);
      end
      if (k >= 2 && gr[k-2]) begin
        expP = gfMul(xg[k-2][3:0] ^ xg[k-2][7:4], yg[k-2][3:0] ^ yg[k-2][7:4]);
        nCmp++;
        if ({mul0Z, mul0B} !== '0) begin
          nErr++;
          $display("FAIL np_zb_hold k%0d: got %h required 0", k, {mul0Z, mul0B});
        end
        nCmp++;
        if ({rsp0Valid, rsp0Id, rsp0Q[3:0] ^ rsp0Q[7:4]} !== {1'b1, 2'd0, expP}) begin
          nErr++;
          $display("FAIL np_rsp k%0d: got v=%b id=%0d p=%h required v=1 id=0 p=%h",
                   k, rsp0Valid, rsp0Id, rsp0Q[3:0] ^ rsp0Q[7:4], expP);
        end
      end else begin
        nCmp++;
        if (rsp0Valid !== 1'b0) begin
          nErr++;
          $display("FAIL np_rsp_idle k%0d: got %b required 0", k, rsp0Valid);
        end
      end
      @(posedge clk);
      #1;
    end
    idleInputs();
  endtask

  task automatic test_reset_midflight();
    doReset();
    rndValid = 1'b1; rnd = 12'h5A7;
    step();
    rndValid = 1'b0;
    reqValid = 4'b1000;
    reqX = $urandom; reqY = $urandom;
    step();
    nCmp++;
    if (lastReady !== 4'b1000) begin
      nErr++;
      $display("FAIL midflight_grant: got %b required 1000", lastReady);
    end
    rndValid = 1'b1;
    doReset();
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_rnd_check();
    logic expErr;
`ifdef DOM_SCHED_RND_CHECK_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    doReset();
    rndValid = 1'b1; rnd = 12'h123;
    step();
    step();
    rndValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nCmp++;
      if (rndErr !== expErr) begin
        nErr++;
        $display("FAIL rnd_check k%0d: got %b required %b", k, rndErr, expErr);
      end
      step();
    end
    doReset();
    step();
  endtask

  initial begin
    idleInputs();
    modelClear();
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_back_to_back();
    test_random();
    test_unpipelined();
    test_reset_midflight();
    test_rnd_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
